// File: rtl/ariane_prf_pkg.sv
// Shared types and sizing for the physical-register free list.
package ariane_prf_pkg;

    localparam int unsigned NR_PHYS_REGS = 64;
    localparam int unsigned NR_ARCH_REGS = 32;
    localparam int unsigned DEPTH        = NR_PHYS_REGS - NR_ARCH_REGS;
    localparam int unsigned PREG_W       = $clog2(NR_PHYS_REGS);
    localparam int unsigned IDX_W        = $clog2(DEPTH);
    localparam int unsigned PTR_W        = IDX_W + 1;

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [PTR_W-1:0]  fl_ptr_t;

    // Storage slot addressed by a pointer (wrap bit stripped).
    function automatic logic [IDX_W-1:0] ptr_idx(input fl_ptr_t p);
        return p[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/ariane_prf_freelist.sv
// Free-list manager for the physical register file: circular FIFO of free
// preg indices with a speculative head (rename), a commit head (retire) and
// a tail (returned pregs). Flush rolls the speculative head back.
// Optional free checking (double free, free while full, free of preg 0) is
// enabled by defining ARIANE_FREELIST_CHECK_EN, which also adds err_o.
module ariane_prf_freelist
    import ariane_prf_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        alloc_req_i,
    output logic        alloc_gnt_o,
    output preg_t       alloc_preg_o,
    input  logic        commit_i,
    input  logic        free_valid_i,
    input  preg_t       free_preg_i,
    input  logic        flush_i,
    output fl_ptr_t     free_cnt_o,
    output logic        empty_o
`ifdef ARIANE_FREELIST_CHECK_EN
   ,output logic        err_o
`endif
);

    fl_ptr_t spec_head_q, spec_head_d;
    fl_ptr_t commit_head_q, commit_head_d;
    fl_ptr_t tail_q, tail_d;
    preg_t   mem_q [DEPTH];

    logic    empty;
    logic    full;
    logic    gnt;
    logic    commit_ok;
    logic    free_ok;
    fl_ptr_t occupied;

    // Pointer arithmetic, grant and acceptance of commits and frees.
    always_comb begin
        empty         = (tail_q == spec_head_q);
        occupied      = tail_q - commit_head_q;
        full          = (occupied == fl_ptr_t'(DEPTH));
        gnt           = alloc_req_i & ~empty & ~flush_i;
        commit_ok     = commit_i & (commit_head_q != spec_head_q);
        commit_head_d = commit_head_q + fl_ptr_t'(commit_ok);
        spec_head_d   = flush_i ? commit_head_d : spec_head_q + fl_ptr_t'(gnt);
        tail_d        = tail_q + fl_ptr_t'(free_ok);
    end

    assign alloc_gnt_o  = gnt;
    assign alloc_preg_o = mem_q[ptr_idx(spec_head_q)];
    assign free_cnt_o   = tail_q - spec_head_q;
    assign empty_o      = empty;

    // Pointer registers; reset leaves the list full with pregs NR_ARCH_REGS..
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            spec_head_q   <= '0;
            commit_head_q <= '0;
            tail_q        <= fl_ptr_t'(DEPTH);
        end else begin
            spec_head_q   <= spec_head_d;
            commit_head_q <= commit_head_d;
            tail_q        <= tail_d;
        end
    end

    // FIFO storage; accepted frees are written at the tail slot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= preg_t'(NR_ARCH_REGS + i);
            end
        end else if (free_ok) begin
            mem_q[ptr_idx(tail_q)] <= free_preg_i;
        end
    end

`ifdef ARIANE_FREELIST_CHECK_EN
    logic [NR_PHYS_REGS-1:0] in_list_q, in_list_d;
    fl_ptr_t                 flush_lo_q, flush_lo_d;
    fl_ptr_t                 flush_n_q, flush_n_d;
    logic                    err_q, err_d;
    logic                    free_bad;

    // Membership tracking; squashed entries are restored the cycle after flush.
    always_comb begin
        free_bad   = free_valid_i & (full | in_list_q[free_preg_i] | (free_preg_i == '0));
        free_ok    = free_valid_i & ~free_bad;
        err_d      = free_bad;
        flush_lo_d = commit_head_d;
        flush_n_d  = flush_i ? (spec_head_q - commit_head_d) : '0;
        in_list_d  = in_list_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (fl_ptr_t'(i) < flush_n_q) begin
                in_list_d[mem_q[ptr_idx(flush_lo_q + fl_ptr_t'(i))]] = 1'b1;
            end
        end
        if (gnt) begin
            in_list_d[alloc_preg_o] = 1'b0;
        end
        if (free_ok) begin
            in_list_d[free_preg_i] = 1'b1;
        end
    end

    // Check-state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NR_PHYS_REGS; i++) begin
                in_list_q[i] <= (i >= NR_ARCH_REGS);
            end
            flush_lo_q <= '0;
            flush_n_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            in_list_q  <= in_list_d;
            flush_lo_q <= flush_lo_d;
            flush_n_q  <= flush_n_d;
            err_q      <= err_d;
        end
    end

    assign err_o = err_q;
`else
    // Unchecked frees: only the full guard applies.
    assign free_ok = free_valid_i & ~full;
`endif

endmodule

// File: tb/tb_ariane_prf_freelist.sv
// Directed bench for ariane_prf_freelist (ARIANE_FREELIST_CHECK_EN optional).
module tb_ariane_prf_freelist;
    import ariane_prf_pkg::*;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    logic    alloc_req = 1'b0;
    logic    gnt;
    preg_t   preg;
    logic    commit = 1'b0;
    logic    free_valid = 1'b0;
    preg_t   free_preg = '0;
    logic    flush = 1'b0;
    fl_ptr_t free_cnt;
    logic    empty;
`ifdef ARIANE_FREELIST_CHECK_EN
    logic    err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ariane_prf_freelist dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .alloc_req_i  (alloc_req),
        .alloc_gnt_o  (gnt),
        .alloc_preg_o (preg),
        .commit_i     (commit),
        .free_valid_i (free_valid),
        .free_preg_i  (free_preg),
        .flush_i      (flush),
        .free_cnt_o   (free_cnt),
        .empty_o      (empty)
`ifdef ARIANE_FREELIST_CHECK_EN
       ,.err_o        (err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        alloc_req  = 1'b0;
        commit     = 1'b0;
        free_valid = 1'b0;
        free_preg  = '0;
        flush      = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        cyc();
    endtask

    task automatic alloc_n(input int n);
        for (int i = 0; i < n; i++) begin
            alloc_req = 1'b1;
            cyc();
        end
        alloc_req = 1'b0;
    endtask

    initial begin
        // Reset state
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_cnt",   free_cnt, 32);
        check("rst_empty", empty,    0);
        check("rst_gnt",   gnt,      0);

        // 1: drain the whole list in order
        for (int i = 0; i < 32; i++) begin
            alloc_req = 1'b1;
            #1;
            check("t1_gnt",  gnt,  1);
            check("t1_preg", preg, 32 + i);
            cyc();
        end
        #1;
        check("t1_empty",   empty,    1);
        check("t1_cnt",     free_cnt, 0);
        check("t1_gnt_off", gnt,      0);

        // 2: alloc 5, commit 2, flush -> rollback to third entry
        do_reset();
        alloc_n(5);
        commit = 1'b1;
        cyc();
        cyc();
        commit = 1'b0;
        flush  = 1'b1;
        alloc_req = 1'b1;
        #1;
        check("t2_flush_gnt", gnt, 0);
        cyc();
        idle();
        check("t2_cnt", free_cnt, 30);
        alloc_req = 1'b1;
        #1;
        check("t2_gnt",  gnt,  1);
        check("t2_preg", preg, 34);
        cyc();
        idle();

        // 3: free into an empty list is not allocatable the same cycle
        do_reset();
        alloc_n(32);
        commit = 1'b1;
        cyc();
        idle();
        alloc_req  = 1'b1;
        free_valid = 1'b1;
        free_preg  = preg_t'(7);
        #1;
        check("t3_same_gnt", gnt, 0);
        cyc();
        free_valid = 1'b0;
        #1;
        check("t3_cnt",  free_cnt, 1);
        check("t3_gnt",  gnt,      1);
        check("t3_preg", preg,     7);
        cyc();
        idle();
        check("t3_empty", empty, 1);

        // 4: free while full is dropped
        do_reset();
        free_valid = 1'b1;
        free_preg  = preg_t'(5);
        cyc();
        idle();
        check("t4_cnt", free_cnt, 32);
`ifdef ARIANE_FREELIST_CHECK_EN
        check("t4_err", err, 1);
        cyc();
        check("t4_err_clr", err, 0);
`endif
        alloc_req = 1'b1;
        #1;
        check("t4_preg", preg, 32);
        cyc();
        idle();

        // Commit with nothing outstanding is ignored (flush must not move head)
        do_reset();
        commit = 1'b1;
        cyc();
        commit = 1'b0;
        flush  = 1'b1;
        cyc();
        idle();
        check("ign_commit_cnt", free_cnt, 32);

        // 5: alloc + commit + free + flush in one cycle
        do_reset();
        alloc_n(3);
        commit = 1'b1;
        cyc();
        alloc_req  = 1'b1;
        commit     = 1'b1;
        free_valid = 1'b1;
        free_preg  = preg_t'(3);
        flush      = 1'b1;
        #1;
        check("t5_gnt", gnt, 0);
        cyc();
        idle();
        check("t5_cnt", free_cnt, 31);
        alloc_req = 1'b1;
        #1;
        check("t5_preg_a", preg, 34);
        cyc();
        for (int i = 0; i < 29; i++) begin
            cyc();
        end
        #1;
        check("t5_wrap_gnt",  gnt,  1);
        check("t5_wrap_preg", preg, 3);
        cyc();
        idle();
        check("t5_empty", empty, 1);

        // 6: asynchronous reset mid-sequence
        do_reset();
        alloc_n(10);
        check("t6_pre_cnt", free_cnt, 22);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_cnt",   free_cnt, 32);
        check("t6_rst_empty", empty,    0);
        #1;
        rst = 1'b0;
        cyc();
        alloc_req = 1'b1;
        #1;
        check("t6_gnt",  gnt,  1);
        check("t6_preg", preg, 32);
        cyc();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
